// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 16-bit MIPS pipeline.
// Data-memory access with a wait-state FSM that stalls upstream, branch
// resolution, and the MEM/WB boundary registers.
// Optional build macro MEM_ALIGN_CHK_EN: suppresses odd-address memory ops
// and flags them on O_misaligned.
module memory_stage #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2,
   parameter int REG_W       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_ALUResult,
   input  logic [DATA_W-1:0] in_Write_Data,
   input  logic              in_Zero,
   input  logic [DATA_W-1:0] in_addResult,
   input  logic [REG_W-1:0]  in_WriteRegister,
   input  logic              in_MemRead,
   input  logic              in_MemWrite,
   input  logic              in_Branch,
   input  logic              in_MemtoReg,
   input  logic              in_RegWrite,
   output logic              O_stall,
   output logic              O_PCSrc,
   output logic [DATA_W-1:0] O_branch_target,
   output logic              O_valid,
   output logic [DATA_W-1:0] O_Read_Data,
   output logic [DATA_W-1:0] O_ALUResult,
   output logic [REG_W-1:0]  O_WriteRegister,
   output logic              O_MemtoReg,
   output logic              O_RegWrite,
   output logic              O_misaligned
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              mem_op;
   logic              misal;
   logic              acc_op;
   logic              stall;
   logic              complete;
   logic              mem_we;

   // Word index: byte address bit 0 dropped, upper bits wrap.
   assign idx    = in_ALUResult[ADDR_W:1];
   assign mem_op = in_valid & (in_MemRead | in_MemWrite);

`ifdef MEM_ALIGN_CHK_EN
   assign misal = mem_op & in_ALUResult[0];
`else
   assign misal = 1'b0;
`endif

   // A misaligned op never reaches memory, so it never stalls either.
   assign acc_op   = mem_op & ~misal;
   assign complete = acc_op & ~stall;
   // Gate with rst so a store in flight when reset hits is dropped.
   assign mem_we   = complete & in_MemWrite & ~rst;

   assign O_stall         = stall;
   assign O_PCSrc         = in_valid & in_Branch & in_Zero & ~stall;
   assign O_branch_target = in_addResult;

   // Wait-state FSM state and counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and stall decode: a memory op holds the pipe WAIT_CYCLES cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (acc_op && (WAIT_CYCLES > 0)) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
               stall     = 1'b1;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               stall   = 1'b1;
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data memory write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= in_Write_Data;
      end
   end

   // ---- MEM/WB boundary: load on completion, bubble while stalled ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         O_valid         <= 1'b0;
         O_Read_Data     <= '0;
         O_ALUResult     <= '0;
         O_WriteRegister <= '0;
         O_MemtoReg      <= 1'b0;
         O_RegWrite      <= 1'b0;
         O_misaligned    <= 1'b0;
      end else if (stall) begin
         O_valid      <= 1'b0;
         O_RegWrite   <= 1'b0;
         O_misaligned <= 1'b0;
      end else begin
         O_valid         <= in_valid;
         O_ALUResult     <= in_ALUResult;
         O_WriteRegister <= in_WriteRegister;
         O_MemtoReg      <= in_MemtoReg;
         O_RegWrite      <= in_valid & in_RegWrite & ~misal;
         O_misaligned    <= misal;
         // Read sees the pre-write word when MemRead and MemWrite coincide.
         if (misal) begin
            O_Read_Data <= '0;
         end else if (complete && in_MemRead) begin
            O_Read_Data <= mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage (WAIT_CYCLES=2 main
// instance, plus a WAIT_CYCLES=0 instance for single-cycle access).
module tb_memory_stage;

   localparam int WAIT = 2;

   typedef struct {
      logic [15:0] rd;
      logic [15:0] alu;
      logic [2:0]  wreg;
      logic        m2r;
      logic        rw;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic        in_valid, in_Zero, in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite;
   logic [15:0] in_ALUResult, in_Write_Data, in_addResult;
   logic [2:0]  in_WriteRegister;
   logic        O_stall, O_PCSrc, O_valid, O_MemtoReg, O_RegWrite, O_misaligned;
   logic [15:0] O_branch_target, O_Read_Data, O_ALUResult;
   logic [2:0]  O_WriteRegister;

   logic        z_valid, z_rd, z_wr, z_ctl;
   logic [15:0] z_alu, z_wd, z_tgt;
   logic [2:0]  z_wreg;
   logic        z_stall, z_pcsrc, z_ovalid, z_m2r, z_rw, z_mis;
   logic [15:0] z_otgt, z_ord, z_oalu;
   logic [2:0]  z_owreg;

   exp_t        sb[$];
   logic [15:0] mdl [256];
   logic [15:0] last_rd;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   memory_stage #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(WAIT), .REG_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ALUResult(in_ALUResult),
      .in_Write_Data(in_Write_Data), .in_Zero(in_Zero), .in_addResult(in_addResult),
      .in_WriteRegister(in_WriteRegister), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
      .in_Branch(in_Branch), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
      .O_stall(O_stall), .O_PCSrc(O_PCSrc), .O_branch_target(O_branch_target),
      .O_valid(O_valid), .O_Read_Data(O_Read_Data), .O_ALUResult(O_ALUResult),
      .O_WriteRegister(O_WriteRegister), .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite),
      .O_misaligned(O_misaligned)
   );

   memory_stage #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .REG_W(3)) dut0 (
      .clk(clk), .rst(rst), .in_valid(z_valid), .in_ALUResult(z_alu),
      .in_Write_Data(z_wd), .in_Zero(z_ctl), .in_addResult(z_tgt),
      .in_WriteRegister(z_wreg), .in_MemRead(z_rd), .in_MemWrite(z_wr),
      .in_Branch(z_ctl), .in_MemtoReg(z_ctl), .in_RegWrite(z_ctl),
      .O_stall(z_stall), .O_PCSrc(z_pcsrc), .O_branch_target(z_otgt),
      .O_valid(z_ovalid), .O_Read_Data(z_ord), .O_ALUResult(z_oalu),
      .O_WriteRegister(z_owreg), .O_MemtoReg(z_m2r), .O_RegWrite(z_rw),
      .O_misaligned(z_mis)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one instruction, predict its MEM/WB entry, then follow it through.
   task automatic issue(input string tag, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [2:0] wreg, input logic m2r, input logic rw,
                        input logic br, input logic zero, input logic [15:0] tgt);
      exp_t       e;
      logic       mop, mis, done;
      logic [7:0] ix;
      int         exp_st, stalls;
      in_valid = 1'b1; in_MemRead = rd; in_MemWrite = wr; in_ALUResult = addr;
      in_Write_Data = wd; in_WriteRegister = wreg; in_MemtoReg = m2r;
      in_RegWrite = rw; in_Branch = br; in_Zero = zero; in_addResult = tgt;
      mop = rd | wr;
`ifdef MEM_ALIGN_CHK_EN
      mis = mop & addr[0];
`else
      mis = 1'b0;
`endif
      ix = addr[8:1];
      exp_st = (mop && !mis) ? WAIT : 0;
      e.rd = mis ? 16'h0000 : (rd ? mdl[ix] : last_rd);
      if (wr && !mis) mdl[ix] = wd;
      last_rd = e.rd;
      e.alu = addr; e.wreg = wreg; e.m2r = m2r; e.rw = rw & ~mis; e.mis = mis;
      sb.push_back(e);
      #1;
      check({tag, "_pcsrc"}, O_PCSrc, br & zero & (exp_st == 0));
      check({tag, "_target"}, O_branch_target, tgt);
      stalls = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check({tag, "_bubble_vld"}, O_valid, 0);
            check({tag, "_bubble_rw"}, O_RegWrite, 0);
         end
         if (!O_stall) done = 1'b1;
         else begin
            stalls++;
            @(posedge clk); #1;
         end
      end
      if (!done) check({tag, "_stall_timeout"}, O_stall, 0);
      check({tag, "_stalls"}, stalls, exp_st);
      @(posedge clk); #1;
      check({tag, "_valid"}, O_valid, 1);
      check({tag, "_sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_rdata"}, O_Read_Data, e.rd);
         check({tag, "_alu"}, O_ALUResult, e.alu);
         check({tag, "_wreg"}, O_WriteRegister, e.wreg);
         check({tag, "_m2r"}, O_MemtoReg, e.m2r);
         check({tag, "_rw"}, O_RegWrite, e.rw);
         check({tag, "_mis"}, O_misaligned, e.mis);
      end
   endtask

   task automatic idle(input string tag);
      in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_Branch = 1'b0;
      @(posedge clk); #1;
      check({tag, "_valid"}, O_valid, 0);
      check({tag, "_rw"}, O_RegWrite, 0);
      check({tag, "_mis"}, O_misaligned, 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_Zero = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
      in_Branch = 1'b0; in_MemtoReg = 1'b0; in_RegWrite = 1'b0;
      in_ALUResult = 16'h0; in_Write_Data = 16'h0; in_addResult = 16'h0; in_WriteRegister = 3'd0;
      z_valid = 1'b0; z_rd = 1'b0; z_wr = 1'b0; z_ctl = 1'b0;
      z_alu = 16'h0; z_wd = 16'h0; z_tgt = 16'h0; z_wreg = 3'd0;
      last_rd = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", O_valid, 0);
      check("rst_rw", O_RegWrite, 0);
      check("rst_rdata", O_Read_Data, 0);
      check("rst_alu", O_ALUResult, 0);
      check("rst_stall", O_stall, 0);
      check("rst_mis", O_misaligned, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Store with wait states, ALU op, load back.
      issue("st04", 0, 1, 16'h0004, 16'h1234, 3'd0, 0, 0, 0, 0, 16'h0000);
      issue("alu", 0, 0, 16'h0077, 16'h0000, 3'd5, 0, 1, 0, 1, 16'h0010);
      issue("ld04", 1, 0, 16'h0004, 16'h0000, 3'd3, 1, 1, 0, 0, 16'h0000);
      // Branch taken / not taken.
      issue("br_t", 0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h0040);
      issue("br_n", 0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 0, 16'h0040);
      // Address wrap.
      issue("st202", 0, 1, 16'h0202, 16'hAAAA, 3'd0, 0, 0, 0, 0, 16'h0000);
      issue("ld002", 1, 0, 16'h0002, 16'h0000, 3'd1, 1, 1, 0, 0, 16'h0000);
      // Read-before-write when both strobes are set.
      issue("rdwr", 1, 1, 16'h0004, 16'h9999, 3'd2, 1, 1, 0, 0, 16'h0000);
      issue("ld04b", 1, 0, 16'h0004, 16'h0000, 3'd4, 1, 1, 0, 0, 16'h0000);
      // Odd address: suppressed with the alignment check, bit 0 ignored otherwise.
      issue("ld05", 1, 0, 16'h0005, 16'h0000, 3'd6, 1, 1, 0, 0, 16'h0000);
      idle("idle1");

      // Reset in the middle of a store's wait states.
      issue("st10", 0, 1, 16'h0010, 16'h1111, 3'd0, 0, 0, 0, 0, 16'h0000);
      in_valid = 1'b1; in_MemRead = 1'b0; in_MemWrite = 1'b1;
      in_ALUResult = 16'h0010; in_Write_Data = 16'hBEEF; in_RegWrite = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mrst_stall", O_stall, 0);
      check("mrst_valid", O_valid, 0);
      check("mrst_rdata", O_Read_Data, 0);
      check("mrst_alu", O_ALUResult, 0);
      check("mrst_wreg", O_WriteRegister, 0);
      check("mrst_m2r", O_MemtoReg, 0);
      check("mrst_rw", O_RegWrite, 0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      last_rd = 16'h0;
      @(posedge clk); #1;
      issue("ld10", 1, 0, 16'h0010, 16'h0000, 3'd7, 1, 1, 0, 0, 16'h0000);
      idle("idle2");

      // Zero-wait instance: stores then back-to-back loads, no stall.
      z_valid = 1'b1; z_wr = 1'b1; z_alu = 16'h0004; z_wd = 16'h5555;
      @(negedge clk); check("z_st04_stall", z_stall, 0);
      @(posedge clk); #1;
      z_alu = 16'h0006; z_wd = 16'h6666;
      @(negedge clk); check("z_st06_stall", z_stall, 0);
      @(posedge clk); #1;
      z_wr = 1'b0; z_rd = 1'b1; z_alu = 16'h0004;
      @(negedge clk); check("z_ld04_stall", z_stall, 0);
      @(posedge clk); #1;
      check("z_ld04_rdata", z_ord, 16'h5555);
      check("z_ld04_valid", z_ovalid, 1);
      z_alu = 16'h0006;
      @(negedge clk); check("z_ld06_stall", z_stall, 0);
      @(posedge clk); #1;
      check("z_ld06_rdata", z_ord, 16'h6666);
      check("z_ld06_alu", z_oalu, 16'h0006);
      z_valid = 1'b0; z_rd = 1'b0;
      @(posedge clk); #1;
      check("z_idle_valid", z_ovalid, 0);

      check("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
